// File: rtl/config_ram_arbiter.sv
// Arbitrates a single-port configuration RAM between a register-file bus and a
// datapath lookup port; the datapath has priority but cannot starve the bus.
module config_ram_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   bus_addr,
  input  logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH/8-1:0] bus_wen,
  input  logic                    bus_rd_strobe,
  output logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    bus_rvalid,
  output logic                    bus_busy,
  output logic                    bus_overrun,
  input  logic                    dp_req,
  input  logic [ADDR_WIDTH-1:0]   dp_addr,
  output logic                    dp_ready,
  output logic [DATA_WIDTH-1:0]   dp_rdata,
  output logic                    dp_rvalid,
  output logic                    ram_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_wen,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int WEN_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  logic                  pend_valid;
  logic                  pend_read;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_wdata;
  logic [WEN_WIDTH-1:0]  pend_wen;
  logic [CNT_WIDTH-1:0]  starve_cnt;
  logic                  overrun_q;
  logic                  bus_rvalid_q;
  logic                  dp_rvalid_q;
  logic [DATA_WIDTH-1:0] bus_rdata_q;

  logic new_req;
  logic bus_grant;
  logic dp_grant;

  assign new_req   = (|bus_wen) | bus_rd_strobe;
  assign bus_grant = pend_valid & (~dp_req | (starve_cnt == CNT_MAX));
  assign dp_grant  = dp_req & ~bus_grant;

  assign dp_ready    = dp_grant;
  assign bus_busy    = pend_valid;
  assign bus_overrun = overrun_q;
  assign bus_rvalid  = bus_rvalid_q;
  assign dp_rvalid   = dp_rvalid_q;
  assign dp_rdata    = ram_rdata;

  // The RAM returns data one cycle after the read, so the response cycle shows
  // it directly; the register holds it for every cycle after that.
  assign bus_rdata = bus_rvalid_q ? ram_rdata : bus_rdata_q;

  assign ram_en    = bus_grant | dp_grant;
  assign ram_addr  = bus_grant ? pend_addr : dp_addr;
  assign ram_wdata = bus_grant ? pend_wdata : '0;
  assign ram_wen   = bus_grant ? pend_wen : '0;

  // A request in the grant cycle refills the slot; one arriving while the slot
  // stays occupied is lost and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_read  <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_wen   <= '0;
      overrun_q  <= 1'b0;
    end else if (new_req && (!pend_valid || bus_grant)) begin
      pend_valid <= 1'b1;
      pend_read  <= ~(|bus_wen);
      pend_addr  <= bus_addr;
      pend_wdata <= bus_wdata;
      pend_wen   <= bus_wen;
    end else begin
      if (new_req) begin
        overrun_q <= 1'b1;
      end
      if (bus_grant) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (bus_grant || !pend_valid) begin
      starve_cnt <= '0;
    end else if (dp_grant && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CNT_WIDTH'(1);
    end
  end

  // Single-cycle read responses; writes complete silently in their grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rvalid_q <= 1'b0;
      dp_rvalid_q  <= 1'b0;
      bus_rdata_q  <= '0;
    end else begin
      bus_rvalid_q <= bus_grant & pend_read;
      dp_rvalid_q  <= dp_grant;
      if (bus_rvalid_q) begin
        bus_rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_config_ram_arbiter.sv
// Scoreboard bench for config_ram_arbiter: directed bus/datapath traffic against
// a behavioural single-port RAM whose unwritten words read as 0xA50000<addr>.
module tb_config_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wen;
  logic        bus_rd_strobe;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_busy;
  logic        bus_overrun;
  logic        dp_req;
  logic [7:0]  dp_addr;
  logic        dp_ready;
  logic [31:0] dp_rdata;
  logic        dp_rvalid;
  logic        ram_en;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad = 0;
  int bus_pulses = 0;
  logic [31:0] dp_exp_q[$];
  logic [31:0] bus_exp_q[$];

  logic [31:0] mem [256];
  bit   [255:0] written;

  always #5 clk = ~clk;

  config_ram_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen),
    .bus_rd_strobe(bus_rd_strobe), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .bus_busy(bus_busy), .bus_overrun(bus_overrun),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_ready(dp_ready),
    .dp_rdata(dp_rdata), .dp_rvalid(dp_rvalid),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    return written[a] ? mem[a] : (32'hA500_0000 | {24'h0, a});
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0] en);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Synchronous single-port RAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 4'h0) begin
        ram_rdata <= ram_word(ram_addr);
      end else begin
        mem[ram_addr]     <= merge_bytes(ram_word(ram_addr), ram_wdata, ram_wen);
        written[ram_addr] <= 1'b1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b_addr, input logic [31:0] b_wdata,
                                input logic [3:0] b_wen, input logic b_rd,
                                input logic d_req, input logic [7:0] d_addr);
    bus_addr      = b_addr;
    bus_wdata     = b_wdata;
    bus_wen       = b_wen;
    bus_rd_strobe = b_rd;
    dp_req        = d_req;
    dp_addr       = d_addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Datapath held busy with a bus read of 0x05 pending; optionally a second
  // bus read arrives while the first is still waiting.
  task automatic run_starve(input logic [7:0] d_addr, input logic second_req);
    logic [7:0] exp_ready;
    exp_ready = 8'b1101_1111;
    apply_stimulus(8'h05, 32'h0, 4'h0, 1'b1, 1'b1, d_addr);
    bus_exp_q.push_back(32'hDEAD_BEEF);
    for (int c = 0; c < 8; c++) begin
      if (c == 1 && second_req) begin
        apply_stimulus(8'h06, 32'h0, 4'h0, 1'b1, 1'b1, d_addr);
      end
      @(negedge clk);
      check_output($sformatf("starve_dp_ready_c%0d", c), 32'(dp_ready), 32'(exp_ready[c]));
      if (exp_ready[c]) dp_exp_q.push_back(32'hA500_0000 | {24'h0, d_addr});
      if (c == 5) begin
        check_output("starve_bus_grant_addr", 32'(ram_addr), 32'h05);
        check_output("starve_bus_grant_wen", 32'(ram_wen), 32'h0);
        check_output("starve_busy_in_grant", 32'(bus_busy), 32'h1);
      end
      if (c == 6) check_output("starve_busy_after", 32'(bus_busy), 32'h0);
      if (second_req && c == 1) check_output("overrun_before", 32'(bus_overrun), 32'h0);
      if (second_req && c == 2) check_output("overrun_set", 32'(bus_overrun), 32'h1);
      step();
      apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b1, d_addr);
    end
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    repeat (3) step();
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dp_rvalid) begin
          if (dp_exp_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL dp_unexpected: got rvalid data %h expected no response", dp_rdata);
          end else begin
            check_output("dp_rdata", dp_rdata, dp_exp_q.pop_front());
          end
        end
        if (bus_rvalid) begin
          bus_pulses++;
          if (bus_exp_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL bus_unexpected: got rvalid data %h expected no response", bus_rdata);
          end else begin
            check_output("bus_rdata", bus_rdata, bus_exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_bus_busy", 32'(bus_busy), 32'h0);
    check_output("rst_bus_overrun", 32'(bus_overrun), 32'h0);
    check_output("rst_bus_rvalid", 32'(bus_rvalid), 32'h0);
    check_output("rst_dp_rvalid", 32'(dp_rvalid), 32'h0);
    check_output("rst_ram_en", 32'(ram_en), 32'h0);
    check_output("rst_ram_wen", 32'(ram_wen), 32'h0);
    check_output("rst_bus_rdata", bus_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Datapath burst over 0x00..0x07 with no bus traffic
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 8'(i));
      dp_exp_q.push_back(32'hA500_0000 + 32'(i));
      @(negedge clk);
      check_output($sformatf("burst_ready_%0d", i), 32'(dp_ready), 32'h1);
      check_output($sformatf("burst_rvalid_%0d", i), 32'(dp_rvalid), (i > 0) ? 32'h1 : 32'h0);
      step();
    end
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("burst_rvalid_last", 32'(dp_rvalid), 32'h1);
    step();
    @(negedge clk);
    check_output("burst_rvalid_end", 32'(dp_rvalid), 32'h0);
    step();

    // Bus write 0xDEADBEEF to 0x05
    apply_stimulus(8'h05, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("wr_busy_request_cycle", 32'(bus_busy), 32'h0);
    step();
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("wr_ram_en", 32'(ram_en), 32'h1);
    check_output("wr_ram_wen", 32'(ram_wen), 32'hF);
    check_output("wr_ram_addr", 32'(ram_addr), 32'h05);
    check_output("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    check_output("wr_busy_grant", 32'(bus_busy), 32'h1);
    step();
    @(negedge clk);
    check_output("wr_busy_after", 32'(bus_busy), 32'h0);
    check_output("wr_ram_en_after", 32'(ram_en), 32'h0);
    step();

    // Bus read of 0x05, then a datapath read proves bus_rdata is held
    apply_stimulus(8'h05, 32'h0, 4'h0, 1'b1, 1'b0, 8'h00);
    bus_exp_q.push_back(32'hDEAD_BEEF);
    step();
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("rd_ram_en", 32'(ram_en), 32'h1);
    check_output("rd_ram_wen", 32'(ram_wen), 32'h0);
    check_output("rd_ram_addr", 32'(ram_addr), 32'h05);
    check_output("rd_rvalid_grant", 32'(bus_rvalid), 32'h0);
    step();
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 8'h20);
    dp_exp_q.push_back(32'hA500_0020);
    @(negedge clk);
    check_output("rd_rvalid_resp", 32'(bus_rvalid), 32'h1);
    step();
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("rd_rvalid_after", 32'(bus_rvalid), 32'h0);
    check_output("rd_rdata_held", bus_rdata, 32'hDEAD_BEEF);
    step();

    run_starve(8'h10, 1'b0);

    // Partial write to 0x07, with a read captured in the write's grant cycle
    apply_stimulus(8'h07, 32'h1234_5678, 4'h3, 1'b0, 1'b0, 8'h00);
    step();
    apply_stimulus(8'h07, 32'h0, 4'h0, 1'b1, 1'b0, 8'h00);
    bus_exp_q.push_back(32'hA500_5678);
    @(negedge clk);
    check_output("b2b_wr_wen", 32'(ram_wen), 32'h3);
    check_output("b2b_wr_addr", 32'(ram_addr), 32'h07);
    step();
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("b2b_rd_busy", 32'(bus_busy), 32'h1);
    check_output("b2b_rd_en", 32'(ram_en), 32'h1);
    check_output("b2b_rd_wen", 32'(ram_wen), 32'h0);
    check_output("b2b_no_overrun", 32'(bus_overrun), 32'h0);
    step();
    @(negedge clk);
    check_output("b2b_rd_rvalid", 32'(bus_rvalid), 32'h1);
    step();

    run_starve(8'h11, 1'b1);
    @(negedge clk);
    check_output("overrun_sticky", 32'(bus_overrun), 32'h1);
    check_output("dropped_not_pending", 32'(bus_busy), 32'h0);
    step();

    // Reset pulsed the cycle after a bus read grant
    apply_stimulus(8'h05, 32'h0, 4'h0, 1'b1, 1'b0, 8'h00);
    step();
    apply_stimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_output("mid_rst_grant", 32'(ram_en), 32'h1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check_output("mid_rst_bus_rvalid", 32'(bus_rvalid), 32'h0);
    check_output("mid_rst_dp_rvalid", 32'(dp_rvalid), 32'h0);
    check_output("mid_rst_busy", 32'(bus_busy), 32'h0);
    check_output("mid_rst_overrun", 32'(bus_overrun), 32'h0);
    check_output("mid_rst_ram_en", 32'(ram_en), 32'h0);
    check_output("mid_rst_ram_wen", 32'(ram_wen), 32'h0);
    check_output("mid_rst_bus_rdata", bus_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check_output("post_rst_overrun", 32'(bus_overrun), 32'h0);
    check_output("bus_response_count", 32'(bus_pulses), 32'd4);
    check_output("dp_queue_drained", 32'(dp_exp_q.size()), 32'd0);
    check_output("bus_queue_drained", 32'(bus_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_ram_arbiter.md
CONFIG_RAM_ARBITER -- requirements
Module: config_ram_arbiter

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- ADDR_WIDTH, 8, RAM word-address width.
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8.
- STARVE_LIMIT, 4, maximum consecutive datapath grants while a bus request is pending.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- bus_addr, in, ADDR_WIDTH, register-file word address.
- bus_wdata, in, DATA_WIDTH, register-file write data.
- bus_wen, in, DATA_WIDTH/8, byte write enables; any bit set starts a write request.
- bus_rd_strobe, in, 1, single-cycle read request.
- bus_rdata, out, DATA_WIDTH, read data; held until the next bus read response.
- bus_rvalid, out, 1, one-cycle bus read-response pulse.
- bus_busy, out, 1, bus request pending.
- bus_overrun, out, 1, sticky flag: a bus request was dropped.
- dp_req, in, 1, datapath lookup request.
- dp_addr, in, ADDR_WIDTH, datapath lookup address.
- dp_ready, out, 1, datapath request accepted this cycle.
- dp_rdata, out, DATA_WIDTH, lookup data.
- dp_rvalid, out, 1, lookup response valid.
- ram_en, out, 1, RAM access enable.
- ram_addr, out, ADDR_WIDTH, RAM address.
- ram_wdata, out, DATA_WIDTH, RAM write data.
- ram_wen, out, DATA_WIDTH/8, RAM byte write enables.
- ram_rdata, in, DATA_WIDTH, RAM read data; valid 1 cycle after a read (ram_en=1, ram_wen=0).

Function
REQ-004 A bus request (bus_wen≠0 or bus_rd_strobe=1) SHALL be captured into a one-deep pending register (addr, wdata, wen, read flag) at the clock edge; bus_busy=1 from the next cycle until the grant cycle, inclusive.
REQ-005 bus_wen≠0 together with bus_rd_strobe=1 SHALL be captured as a write only.
REQ-006 A new bus request arriving while bus_busy=1 SHALL be dropped and SHALL set bus_overrun, which is cleared only by reset.
REQ-007 A new bus request in the same cycle the pending request is granted SHALL be captured, not dropped.
REQ-008 Each cycle, at most one requester SHALL be granted: the datapath (dp_req=1) has priority unless the starvation counter equals STARVE_LIMIT and a bus request is pending, in which case the bus is granted.
REQ-009 The starvation counter SHALL increment on each datapath grant while a bus request is pending, saturate at STARVE_LIMIT, and clear on a bus grant or when no bus request is pending.
REQ-010 dp_ready SHALL equal dp_req and not (bus grant this cycle), combinationally.
REQ-011 On a grant, the RAM outputs SHALL be driven as follows: ram_en=1; ram_addr from the granted source; ram_wen = pending wen for a bus write, else 0. With no grant, ram_en=0 and ram_wen=0.
REQ-012 A datapath grant in cycle G SHALL produce dp_rvalid=1 in cycle G+1, with dp_rdata=ram_rdata.
REQ-013 A bus read grant in cycle G SHALL produce bus_rvalid=1 in cycle G+1, with bus_rdata=ram_rdata; bus_rdata SHALL be registered and hold that value afterwards.
REQ-014 Bus writes SHALL produce no response and SHALL complete in the grant cycle.
REQ-015 Responses SHALL be in grant order; latency is exactly 1 cycle after grant, with no back-pressure on responses.

Reset
REQ-016 While rst_n=0, the block SHALL drive: pending register empty, bus_busy=0, bus_overrun=0, bus_rvalid=0, dp_rvalid=0, ram_en=0, ram_wen=0, starvation counter=0, bus_rdata=0.
REQ-017 Reset asserted mid-operation SHALL discard any pending request and any in-flight response; no rvalid SHALL appear after rst_n deasserts without a new grant.

Verification
REQ-018 Bus write addr 0x05, wdata 0xDEADBEEF, wen 0xF, no dp_req -> ram_en=1, ram_wen=0xF, ram_addr=0x05 one cycle later; bus_busy high for 1 cycle.
REQ-019 Bus read addr 0x05 (RAM holds 0xDEADBEEF) -> bus_rvalid pulses 1 cycle after grant; bus_rdata=0xDEADBEEF and held.
REQ-020 dp_req held high continuously with a bus read pending, STARVE_LIMIT=4 -> exactly 4 datapath grants, then 1 bus grant (dp_ready=0 that cycle), then datapath resumes.
REQ-021 Second bus_rd_strobe while bus_busy=1 -> bus_overrun=1 sticky; only one bus_rvalid observed.
REQ-022 Back-to-back dp_req on addresses 0x00..0x07 with no bus traffic -> 8 consecutive dp_rvalid cycles, data in address order, 1-cycle latency.
REQ-023 rst_n pulsed low during the cycle after a bus read grant -> no bus_rvalid; all outputs at their REQ-016 values; bus_overrun=0.
